// File: rtl/reduce_feeder.sv
// Purpose: streams a preloaded BUFFER_DEPTH-word buffer into the reducer, then captures its result.
// Latency: first word valid 1 cycle after start; done pulses 1 cycle after result capture or timeout.
// Backpressure: tx_data/tx_valid hold while tx_ready=0; buffer writes are dropped while a run is active.
module reduce_feeder #(
  parameter int BUFFER_DEPTH = 256,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // buffer preload port
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  // run control
  input  logic              start,
  output logic              busy,
  // stream towards the reducer
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  // reducer result
  input  logic [31:0]       res_data,
  input  logic              res_valid,
  // run outcome
  output logic [31:0]       result,
  output logic              done,
  output logic              timeout_err
);

  // wait_cnt only ever needs to reach TIMEOUT-1
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W:0]  LAST_SENT  = (ADDR_W+1)'(BUFFER_DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_EXT  = (ADDR_W+1)'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // local word buffer; contents survive reset
  logic [31:0] mem [BUFFER_DEPTH];

  // read pointer runs one word ahead of the word currently presented on tx_data
  logic [ADDR_W-1:0] rd_ptr;
  // number of words already accepted by the sink in this run
  logic [ADDR_W:0]   sent;
  logic [CNT_W-1:0]  wait_cnt;

  // single-cycle control strobes decoded from the FSM
  logic load_first;
  logic advance;
  logic stream_end;
  logic capture;
  logic expire;
  logic wr_accept;
  logic handshake;

  assign handshake = tx_valid && tx_ready;

  // buffer is only writable between runs, so a run always sees a frozen snapshot
  assign wr_accept = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < DEPTH_EXT);

  assign busy = (state_q != S_IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode and datapath control strobes
  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    advance    = 1'b0;
    stream_end = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_STREAM;
          load_first = 1'b1;
        end
      end
      S_STREAM: begin
        if (handshake) begin
          if (sent == LAST_SENT) begin
            stream_end = 1'b1;
            state_d    = S_WAIT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // a result arriving on the limit cycle still counts as success
        if (res_valid) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // buffer write port; a write coincident with start commits after word 0 is read
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // stream datapath, wait counter and registered run outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      rd_ptr      <= '0;
      sent        <= '0;
      wait_cnt    <= '0;
      result      <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= capture | expire;

      if (load_first) begin
        tx_data     <= mem[{ADDR_W{1'b0}}];
        tx_valid    <= 1'b1;
        rd_ptr      <= ADDR_W'(1);
        sent        <= '0;
        timeout_err <= 1'b0;
      end

      // rd_ptr wraps to 0 after the final word; that value is never used
      if (advance) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        sent    <= sent + (ADDR_W+1)'(1);
      end

      if (stream_end) begin
        tx_valid <= 1'b0;
        wait_cnt <= '0;
      end

      if ((state_q == S_WAIT) && !capture && !expire) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (capture) begin
        result <= res_data;
      end

      if (expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reduce_feeder.sv
// Bench for reduce_feeder: directed sequence of runs with randomized data, pacing and result timing.
// Expected stream/result come from a plain array model of the buffer and a summing reducer model.
// Outputs are sampled and inputs driven 1 time unit after each rising edge.
module tb_reduce_feeder;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int TO    = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          start;
  logic          busy;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   res_data;
  logic          res_valid;
  logic [31:0]   result;
  logic          done;
  logic          timeout_err;

  int vectors;
  int miscompares;

  logic [31:0] model_buf [DEPTH];
  logic [31:0] model_result;
  logic        model_terr;

  reduce_feeder #(
    .BUFFER_DEPTH(DEPTH),
    .ADDR_W      (AW),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .result     (result),
    .done       (done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    cycle();
    wr_en = 1'b0;
    model_buf[addr] = data;
  endtask

  // One run: mode 0 ready=1, 1 toggling, 2 random. Result appears 'delay' cycles into WAIT
  // (give_res=0 forces timeout). disturb adds locked-buffer writes, stray res_valid and start
  // pulses while busy. abort_at>=0 resets while that word is presented. same_wr writes buf[0]
  // in the start cycle. linger adds one post-run idle check (0 lets the next run start back-to-back).
  task automatic run(input int mode, input bit give_res, input int delay, input bit disturb,
                     input int abort_at, input bit same_wr, input logic [31:0] same_data,
                     input bit linger);
    logic [31:0] exp_q [$];
    logic [31:0] sum;
    int idx;
    int budget;
    int j;
    bit fin;
    bit success;
    sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(model_buf[k]);
      sum += model_buf[k];
    end
    start = 1'b1;
    if (same_wr) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = same_data;
      model_buf[0] = same_data;
    end
    cycle();
    start = 1'b0;
    wr_en = 1'b0;
    model_terr = 1'b0;
    chk("busy_run", busy, 1);
    chk("terr_clr", timeout_err, model_terr);
    chk("done_clr", done, 0);

    idx = 0;
    budget = 0;
    while (idx < DEPTH && budget < 8 * DEPTH) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (budget % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (disturb) begin
        wr_en     = 1'b1;
        wr_addr   = AW'(5);
        wr_data   = 32'hDEADBEEF;
        res_valid = 1'($urandom_range(0, 1));
        res_data  = $urandom;
        start     = 1'($urandom_range(0, 1));
      end
      chk("tx_valid", tx_valid, 1);
      chk("tx_data", tx_data, exp_q[idx]);
      chk("done_stream", done, 0);
      if (idx == abort_at) begin
        rst = 1'b1;
        wr_en = 1'b0;
        start = 1'b0;
        res_valid = 1'b0;
        cycle();
        rst = 1'b0;
        model_result = '0;
        chk("abort_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_data", tx_data, 0);
        chk("abort_result", result, model_result);
        chk("abort_terr", timeout_err, 0);
        cycle();
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        return;
      end
      if (tx_ready) idx++;
      cycle();
      budget++;
    end
    chk("words_sent", idx, DEPTH);
    start = 1'b0;
    chk("valid_drop", tx_valid, 0);
    chk("busy_wait", busy, 1);
    chk("done_early", done, 0);

    j = 0;
    fin = 1'b0;
    success = 1'b0;
    while (!fin) begin
      res_valid = give_res && (j >= delay);
      res_data  = res_valid ? sum : $urandom;
      if (disturb) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = 32'hDEADBEEF;
      end
      success = res_valid;
      fin = res_valid || (j == TO - 1);
      cycle();
      start = 1'b0;
      wr_en = 1'b0;
      res_valid = 1'b0;
      if (!fin) begin
        chk("done_wait", done, 0);
        chk("busy_in_wait", busy, 1);
      end
      j++;
    end
    if (success) model_result = sum;
    else model_terr = 1'b1;
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
    chk("result", result, model_result);
    chk("timeout_err", timeout_err, model_terr);
    if (linger) begin
      cycle();
      chk("done_one_cycle", done, 0);
      chk("idle_after", busy, 0);
      chk("no_rerun", tx_valid, 0);
      chk("result_hold", result, model_result);
      chk("terr_sticky", timeout_err, model_terr);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    tx_ready = 1'b1;
    res_valid = 1'b0;
    res_data = '0;
    model_result = '0;
    model_terr = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);

    // ramp fill, full-rate sink, reducer returns the sum
    for (int i = 0; i < DEPTH; i++) write_word(i, 32'(i));
    run(0, 1'b1, 2, 1'b0, -1, 1'b0, '0, 1'b1);
    chk("sum_32640", result, 32'd32640);

    // same data, sink ready toggling every cycle
    run(1, 1'b1, int'($urandom_range(0, 5)), 1'b0, -1, 1'b0, '0, 1'b1);

    // no result: timeout keeps prior result, next start clears the flag
    run(0, 1'b0, 0, 1'b0, -1, 1'b0, '0, 1'b1);
    run(2, 1'b1, 3, 1'b0, -1, 1'b0, '0, 1'b1);

    // random fill; writes and starts while busy must be ignored
    for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);
    write_word(5, 32'h0000_0555);
    run(1, 1'b1, 4, 1'b1, -1, 1'b0, '0, 1'b1);
    run(2, 1'b1, 1, 1'b0, -1, 1'b0, '0, 1'b1);

    // reset at word 100, then a full resend from buf[0]
    run(0, 1'b1, 0, 1'b0, 100, 1'b0, '0, 1'b1);
    run(0, 1'b1, 2, 1'b0, -1, 1'b0, '0, 1'b1);

    // write coincident with start: old word 0 goes out, new one next run
    write_word(0, 32'd3);
    run(0, 1'b1, 1, 1'b0, -1, 1'b1, 32'd7, 1'b0);
    // back-to-back start on the done cycle; result on the limit cycle wins
    run(1, 1'b1, TO - 1, 1'b0, -1, 1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reduce_feeder.md
Name: reduce_feeder

Overview:
- Transmit-side companion to the reduction engine.
- Software or a host FSM preloads BUFFER_DEPTH 32-bit words into a local buffer through a write port.
- On start, the block streams exactly BUFFER_DEPTH words to the reducer's input (data/valid, with optional ready pacing), then waits for the reducer's result and captures it.
- Reports completion or timeout.

Parameters:
- BUFFER_DEPTH, 256, words per reduction run; must equal the reducer's BUFFER_DEPTH; power of two, 2..1024.
- ADDR_W, 8, buffer address width; 2**ADDR_W == BUFFER_DEPTH.
- TIMEOUT, 1024, maximum cycles in WAIT before abort; >= 1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_W  buffer write address.
- wr_data  in  32  buffer write data.
- start  in  1  begin a run (one-cycle pulse or level; sampled only in IDLE).
- busy  out  1  high when state != IDLE.
- tx_data  out  32  word to reducer in_data.
- tx_valid  out  1  to reducer in_valid.
- tx_ready  in  1  sink ready; tie 1 when the sink has no backpressure.
- res_data  in  32  reducer result.
- res_valid  in  1  reducer result valid.
- result  out  32  captured sum; held until the next successful capture.
- done  out  1  one-cycle pulse at end of run (success or timeout).
- timeout_err  out  1  sticky error flag; cleared on next accepted start.

Behaviour:
- Reset (clock edge with rst=1), from any state:
  - FSM -> IDLE.
  - tx_valid=0, tx_data=0, result=0, done=0, timeout_err=0, busy=0.
  - Internal pointer/counters = 0.
  - Buffer contents not reset.
  - Reset mid-STREAM/WAIT aborts with no done pulse.
  - Outputs take reset values the cycle after the rst edge.
- Clock and reset: one clock (clk); reset synchronous, active-high (rst).
- FSM states: IDLE, STREAM, WAIT.
- All outputs registered; busy decoded from state register.
- Buffer writes:
  - Accepted only in IDLE when wr_en=1 and wr_addr < BUFFER_DEPTH.
  - Writes in STREAM/WAIT are dropped (buffer locked during a run).
- IDLE -> STREAM on start=1:
  - Next cycle: tx_data=buf[0], tx_valid=1, rd_ptr=1, sent=0, timeout_err=0.
  - Latency start-to-first-valid is 1 cycle.
  - If wr_en and start occur in the same cycle, the write commits, but word 0 is read-before-write (old buf[0] sent if wr_addr==0).
- STREAM:
  - Handshake = tx_valid & tx_ready.
  - tx_data/tx_valid hold stable while tx_ready=0.
  - On handshake with sent < BUFFER_DEPTH-1: tx_data<=buf[rd_ptr], rd_ptr++, sent++.
  - On handshake with sent == BUFFER_DEPTH-1: tx_valid<=0, wait_cnt<=0, go WAIT.
  - With tx_ready held 1: exactly BUFFER_DEPTH consecutive valid cycles, buf[0..N-1] in order.
  - sent is ADDR_W+1 bits; rd_ptr wraps to 0 harmlessly after the last word.
- WAIT:
  - res_valid is level-sensitive.
  - First cycle with res_valid=1: result<=res_data, done<=1 for one cycle, go IDLE.
  - Otherwise wait_cnt++.
  - When wait_cnt reaches TIMEOUT-1 without res_valid: timeout_err<=1, done<=1, result unchanged, go IDLE.
  - If res_valid arrives in the same cycle as the timeout limit, success wins (result captured, no error).
- res_valid in IDLE/STREAM is ignored.
- start while busy is ignored (no queueing).
- A new run may start the cycle after done (back-to-back).

Test Plan:
- Fill buf[i]=i (i=0..255), start, tx_ready=1, model reducer returns sum -> tx_valid high exactly 256 consecutive cycles starting 1 cycle after start, tx_data 0..255 in order; res_data=32640 -> result=32640, one-cycle done, busy falls with done.
- Same fill, tx_ready toggling 1,0,1,0 -> 256 handshakes, tx_data stable across every stalled cycle, no word duplicated or skipped.
- Start with no res_valid, TIMEOUT=16 -> done pulse 16 cycles after entering WAIT, timeout_err=1, result keeps prior value; next start clears timeout_err.
- Writes (addr 5, data 0xDEADBEEF) during STREAM and start pulses during WAIT -> buffer unchanged on the following run, no second run triggered.
- rst asserted at word 100 of STREAM -> next cycle tx_valid=0, busy=0, no done; a subsequent start resends from buf[0] with retained buffer data.
- Same-cycle wr_en(addr 0, data 7) and start with buf[0]=3 -> first tx_data=3; the next run sends 7 first.
